// File: rtl/fifo_rr_drain_pkg.sv
// Shared types and defaults for the round-robin FIFO drain controller and
// the FIFO bank it serves.
package fifo_rr_drain_pkg;

    localparam int unsigned DEF_NUM_FIFO = 8;
    localparam int unsigned DEF_WIDTH    = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StFlush = 2'd2,
        StDone  = 2'd3
    } drain_state_e;

    // Index width for an N-entry selector; never zero so N=1 still elaborates.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_drain_rr_arbiter.sv
// Combinational rotate-priority arbiter: searches from last_grant+1 upward
// (mod N) and grants the first requester when enabled.
module rr_arbiter
    import fifo_rr_drain_pkg::*;
#(
    parameter int unsigned N = DEF_NUM_FIFO,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        if (en) begin
            // Offset N wraps back to last_grant itself, so it is checked last.
            for (int unsigned i = 1; i <= N; i++) begin
                cand = IW'((32'(last_grant) + i) % N);
                if (!grant_valid && req[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                    grant[cand] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of a FIFO bank into consecutive SRAM addresses through a
// registered valid/ready write port; one word per cycle, done pulse at the end.
module fifo_rr_drain
    import fifo_rr_drain_pkg::*;
#(
    parameter int unsigned NUM_FIFO = DEF_NUM_FIFO,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned LEN_W    = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic [ADDR_W-1:0]         i_base_addr,
    input  logic [LEN_W-1:0]          i_len,
    input  logic [NUM_FIFO-1:0]       i_fifo_empty,
    input  logic [NUM_FIFO*WIDTH-1:0] i_fifo_data,
    output logic [NUM_FIFO-1:0]       o_fifo_rd,
    output logic                      o_wr_en,
    output logic [ADDR_W-1:0]         o_wr_addr,
    output logic [WIDTH-1:0]          o_wr_data,
    input  logic                      i_wr_ready,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int unsigned IW = idx_w(NUM_FIFO);

    drain_state_e      state_q;
    logic [LEN_W-1:0]  rem_q;
    logic [ADDR_W-1:0] addr_q;
    logic [IW-1:0]     last_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [WIDTH-1:0]  wr_data_q;
    logic              busy_q;
    logic              done_q;

    logic                slot_free;
    logic                arb_en;
    logic [NUM_FIFO-1:0] fifo_req;
    logic [NUM_FIFO-1:0] grant;
    logic [IW-1:0]       grant_idx;
    logic                grant_valid;
    logic [WIDTH-1:0]    pop_data;
    logic [LEN_W-1:0]    rem_dec;

    assign slot_free = !wr_en_q || i_wr_ready;
    assign arb_en    = (state_q == StDrain) && (rem_q != '0) && slot_free;
    assign fifo_req  = ~i_fifo_empty;
    assign rem_dec   = rem_q - LEN_W'(1);

    rr_arbiter #(
        .N(NUM_FIFO)
    ) u_arb (
        .req        (fifo_req),
        .en         (arb_en),
        .last_grant (last_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    // Grant is one-hot, so an OR of the selected slices is the head-word mux.
    always_comb begin
        pop_data = '0;
        for (int unsigned k = 0; k < NUM_FIFO; k++) begin
            if (grant[k]) begin
                pop_data = pop_data | i_fifo_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            addr_q    <= '0;
            last_q    <= IW'(NUM_FIFO - 1);
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        addr_q <= i_base_addr;
                        rem_q  <= i_len;
                        busy_q <= 1'b1;
                        if (i_len != '0) begin
                            state_q <= StDrain;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (grant_valid) begin
                        wr_data_q <= pop_data;
                        wr_addr_q <= addr_q;
                        wr_en_q   <= 1'b1;
                        addr_q    <= addr_q + ADDR_W'(1);
                        rem_q     <= rem_dec;
                        last_q    <= grant_idx;
                        if (rem_dec == '0) begin
                            state_q <= StFlush;
                        end
                    end else if (slot_free) begin
                        wr_en_q <= 1'b0;
                    end
                end
                StFlush: begin
                    if (!wr_en_q || i_wr_ready) begin
                        wr_en_q <= 1'b0;
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_fifo_rd = grant;
    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Directed bench for fifo_rr_drain: a per-cycle vector table for a single-FIFO
// drain, then hand-written sequences for fairness, stalls, wrap and resets.
module tb_fifo_rr_drain;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic [10:0]   i_base_addr;
    logic [11:0]   i_len;
    logic [7:0]    i_fifo_empty;
    logic [255:0]  i_fifo_data;
    logic [7:0]    o_fifo_rd;
    logic          o_wr_en;
    logic [10:0]   o_wr_addr;
    logic [31:0]   o_wr_data;
    logic          i_wr_ready;
    logic          o_busy;
    logic          o_done;

    fifo_rr_drain dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_len       (i_len),
        .i_fifo_empty(i_fifo_empty),
        .i_fifo_data (i_fifo_data),
        .o_fifo_rd   (o_fifo_rd),
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .i_wr_ready  (i_wr_ready),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        ready;
        logic [7:0]  rd;
        logic        en;
        logic [10:0] addr;
        logic [31:0] data;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t        vecs[8];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] mem[8][16];
    int          rdp[8];
    int          wrp[8];
    int          grant_q[$];
    logic [10:0] waddr_q[$];
    logic [31:0] wdata_q[$];
    int          exp_g[$];
    logic [31:0] exp_d[$];
    int          done_cnt;

    function automatic logic [31:0] word(input int k, input int j);
        return {8'(k), 8'hC0, 16'(j)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic refresh();
        for (int k = 0; k < 8; k++) begin
            i_fifo_empty[k] = (rdp[k] == wrp[k]);
            i_fifo_data[k*32 +: 32] = (rdp[k] == wrp[k]) ? 32'hDEAD_0000 : mem[k][rdp[k]];
        end
    endtask

    task automatic load_fifo(input int k, input logic [31:0] w);
        mem[k][wrp[k]] = w;
        wrp[k]++;
        refresh();
    endtask

    task automatic clear_sb();
        grant_q.delete();
        waddr_q.delete();
        wdata_q.delete();
        exp_g.delete();
        exp_d.delete();
        done_cnt = 0;
    endtask

    // Called at a negedge with inputs set: sample, clock, apply pops to the FIFO model.
    task automatic step();
        int g;
        g = -1;
        #1;
        if (o_fifo_rd != '0) begin
            chk("rd_onehot", 64'($onehot(o_fifo_rd)), 64'd1);
            for (int k = 0; k < 8; k++) if (o_fifo_rd[k]) g = k;
            chk("pop_nonempty", 64'(i_fifo_empty[g]), 64'd0);
            grant_q.push_back(g);
        end
        if (o_wr_en && i_wr_ready) begin
            waddr_q.push_back(o_wr_addr);
            wdata_q.push_back(o_wr_data);
        end
        if (o_done) done_cnt++;
        @(posedge clk);
        #1;
        if (g >= 0 && rdp[g] != wrp[g]) rdp[g]++;
        refresh();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_start = 1'b0;
        i_base_addr = '0;
        i_len = '0;
        i_wr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rdp[k] = 0;
            wrp[k] = 0;
        end
        refresh();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_sb();
    endtask

    task automatic start_cmd(input logic [10:0] base, input logic [11:0] len);
        i_base_addr = base;
        i_len = len;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (done_cnt != 0) seen = 1'b1;
        end
        chk("done_seen", 64'(seen), 64'd1);
        #1;
        chk("done_single_pulse", 64'(done_cnt), 64'd1);
        chk("idle_after_done", {62'd0, o_busy, o_done}, 64'd0);
    endtask

    task automatic check_xfer(input logic [10:0] base);
        chk("grant_count", 64'(grant_q.size()), 64'(exp_g.size()));
        chk("write_count", 64'(waddr_q.size()), 64'(exp_g.size()));
        for (int i = 0; i < exp_g.size(); i++) begin
            if (i < grant_q.size()) chk("grant_order", 64'(grant_q[i]), 64'(exp_g[i]));
            if (i < waddr_q.size()) begin
                chk("wr_addr", 64'(waddr_q[i]), 64'(11'(base + i)));
                chk("wr_data", 64'(wdata_q[i]), 64'(exp_d[i]));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single FIFO 2 holding 4 words, base 0x010, len 4, no backpressure.
        vecs[0] = '{1'b1, 1'b1, 8'h00, 1'b0, 11'h000, 32'h0,         1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'h04, 1'b0, 11'h000, 32'h0,         1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'h04, 1'b1, 11'h010, 32'h02C0_0000, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 8'h04, 1'b1, 11'h011, 32'h02C0_0001, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h04, 1'b1, 11'h012, 32'h02C0_0002, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 1'b1, 11'h013, 32'h02C0_0003, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 1'b0, 11'h000, 32'h0,         1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 8'h00, 1'b0, 11'h000, 32'h0,         1'b0, 1'b0};

        rst_n = 1'b0;
        i_start = 1'b0;
        i_wr_ready = 1'b1;
        i_base_addr = '0;
        i_len = '0;
        for (int k = 0; k < 8; k++) begin
            rdp[k] = 0;
            wrp[k] = 0;
        end
        refresh();
        #1;
        chk("reset_outputs", {o_fifo_rd, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done}, 64'd0);
        do_reset();

        for (int j = 0; j < 4; j++) load_fifo(2, word(2, j));
        i_base_addr = 11'h010;
        i_len = 12'd4;
        for (int i = 0; i < 8; i++) begin
            i_start = vecs[i].start;
            i_wr_ready = vecs[i].ready;
            #1;
            chk("tbl_rd", 64'(o_fifo_rd), 64'(vecs[i].rd));
            chk("tbl_wr_en", 64'(o_wr_en), 64'(vecs[i].en));
            chk("tbl_busy", 64'(o_busy), 64'(vecs[i].busy));
            chk("tbl_done", 64'(o_done), 64'(vecs[i].done));
            if (vecs[i].en) begin
                chk("tbl_wr_addr", 64'(o_wr_addr), 64'(vecs[i].addr));
                chk("tbl_wr_data", 64'(o_wr_data), 64'(vecs[i].data));
            end
            step();
        end

        // Fairness: all FIFOs loaded, 16 words -> strict 0..7 rotation twice.
        do_reset();
        for (int k = 0; k < 8; k++) for (int j = 0; j < 2; j++) load_fifo(k, word(k, j));
        for (int i = 0; i < 16; i++) begin
            exp_g.push_back(i % 8);
            exp_d.push_back(word(i % 8, i / 8));
        end
        start_cmd(11'h100, 12'd16);
        run_until_done(40);
        check_xfer(11'h100);

        // Backpressure: ready low for 5 cycles after the first write appears.
        do_reset();
        for (int j = 0; j < 3; j++) begin
            load_fifo(0, word(0, j));
            exp_g.push_back(0);
            exp_d.push_back(word(0, j));
        end
        start_cmd(11'h020, 12'd3);
        step();
        i_wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_wr_en", 64'(o_wr_en), 64'd1);
            chk("stall_addr", 64'(o_wr_addr), 64'h020);
            chk("stall_data", 64'(o_wr_data), 64'(word(0, 0)));
            chk("stall_no_pop", 64'(o_fifo_rd), 64'd0);
            step();
        end
        i_wr_ready = 1'b1;
        run_until_done(20);
        check_xfer(11'h020);

        // Sparse FIFOs 1 and 6 with the address counter wrapping past 0x7FF.
        do_reset();
        for (int j = 0; j < 2; j++) begin
            load_fifo(1, word(1, j));
            load_fifo(6, word(6, j));
        end
        exp_g = '{1, 6, 1, 6};
        exp_d = '{word(1, 0), word(6, 0), word(1, 1), word(6, 1)};
        start_cmd(11'h7FE, 12'd4);
        run_until_done(20);
        check_xfer(11'h7FE);

        // len=0: done pulse, no pop, no write, even with data waiting.
        do_reset();
        load_fifo(3, word(3, 0));
        start_cmd(11'h030, 12'd0);
        #1;
        chk("len0_done", 64'(o_done), 64'd1);
        chk("len0_busy", 64'(o_busy), 64'd1);
        chk("len0_no_pop", 64'(o_fifo_rd), 64'd0);
        chk("len0_no_wr", 64'(o_wr_en), 64'd0);
        step();
        #1;
        chk("len0_idle", {62'd0, o_busy, o_done}, 64'd0);
        chk("len0_grants", 64'(grant_q.size()), 64'd0);
        chk("len0_writes", 64'(waddr_q.size()), 64'd0);

        // Start held while busy with a different command must be ignored.
        clear_sb();
        load_fifo(3, word(3, 1));
        exp_g = '{3, 3};
        exp_d = '{word(3, 0), word(3, 1)};
        i_base_addr = 11'h040;
        i_len = 12'd2;
        i_start = 1'b1;
        step();
        i_base_addr = 11'h300;
        i_len = 12'd5;
        step();
        step();
        i_start = 1'b0;
        run_until_done(20);
        check_xfer(11'h040);

        // Async reset after 2 of 8 words, then a fresh command from the leftovers.
        do_reset();
        for (int j = 0; j < 8; j++) load_fifo(5, word(5, j));
        start_cmd(11'h050, 12'd8);
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", 64'(o_wr_en), 64'd0);
        chk("arst_busy", 64'(o_busy), 64'd0);
        chk("arst_rd", 64'(o_fifo_rd), 64'd0);
        chk("arst_addr_data", {21'd0, o_wr_addr, o_wr_data}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_sb();
        exp_g = '{5, 5, 5};
        exp_d = '{word(5, 2), word(5, 3), word(5, 4)};
        start_cmd(11'h060, 12'd3);
        run_until_done(20);
        check_xfer(11'h060);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
